hazard_ctrl_sb: RTL and testbench

//  Parametrised pipeline interlock/forwarding controller for the 5-stage F/D/E/M/W core.

---
 rtl/hazard_ctrl_sb_pkg.sv | 23 ++
 rtl/hazard_ctrl_sb_if.sv | 40 ++++
 rtl/hazard_ctrl_sb_fwd_sel.sv | 31 +++
 rtl/hazard_ctrl_sb.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl_sb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_sb_pkg
//  Description : Shared encodings for the hazard/forwarding controller:
//                forward-select values and exception-flush FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_sb_pkg;

    // Operand source selects driven to the datapath bypass muxes
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Exception-flush state machine
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_sb_if
//  Description : Datapath <-> hazard controller signal bundle. The datapath
//                (master) reports stage contents; the controller (slave)
//                returns stall/flush/forward controls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_sb_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [REG_AW-1:0] wreg_e, wreg_m, wreg_w;
    logic              use_rs_d, use_rt_d, cmp_d;
    logic              we_e, we_m, we_w;
    logic              ll_e, ll_m, mdu_busy_e, except_m, mem_stall;
    logic              stall_f, stall_d, stall_e, stall_m, stall_w;
    logic              flush_d, flush_e, flush_m, flush_w;
    logic [1:0]        fwd_ad, fwd_bd, fwd_ae, fwd_be;
    logic              exc_redirect, stall_timeout;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
               use_rs_d, use_rt_d, cmp_d, we_e, we_m, we_w,
               ll_e, ll_m, mdu_busy_e, except_m, mem_stall,
        input  stall_f, stall_d, stall_e, stall_m, stall_w,
               flush_d, flush_e, flush_m, flush_w,
               fwd_ad, fwd_bd, fwd_ae, fwd_be, exc_redirect, stall_timeout
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
               use_rs_d, use_rt_d, cmp_d, we_e, we_m, we_w,
               ll_e, ll_m, mdu_busy_e, except_m, mem_stall,
        output stall_f, stall_d, stall_e, stall_m, stall_w,
               flush_d, flush_e, flush_m, flush_w,
               fwd_ad, fwd_bd, fwd_ae, fwd_be, exc_redirect, stall_timeout
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_sb_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hz_fwd_sel
//  Description : Single-operand bypass select. M-stage producer has priority
//                over W; register 0 is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_fwd_sel
    import hazard_ctrl_sb_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  wire logic [REG_AW-1:0] i_src,
    input  wire logic [REG_AW-1:0] i_wreg_m,
    input  wire logic [REG_AW-1:0] i_wreg_w,
    input  wire logic              i_we_m,
    input  wire logic              i_we_w,
    output logic      [1:0]        o_sel
);

    // Youngest matching producer wins
    always_comb begin
        o_sel = FWD_RF;
        if (i_src != '0) begin
            if (i_we_m && (i_wreg_m == i_src))      o_sel = FWD_M;
            else if (i_we_w && (i_wreg_w == i_src)) o_sel = FWD_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_sb
//  Description : 5-stage pipeline interlock/forwarding controller with a
//                pending-write scoreboard for long-latency producers, a
//                latched exception-flush FSM and a D-stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_sb
    import hazard_ctrl_sb_pkg::*;
#(
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = 5,
    parameter int WDOG_MAX = 1023
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    hazard_ctrl_sb_if.slave   bus
);

    localparam int              WDW         = $clog2(WDOG_MAX + 1);
    localparam logic [WDW-1:0] c_wdog_max  = WDW'(WDOG_MAX);
    localparam logic [WDW-1:0] c_wdog_pre  = WDW'(WDOG_MAX - 1);

    logic [REG_NUM-1:0] r_pend;
    hz_state_t          r_state;
    logic [WDW-1:0]     r_wdog;
    logic               r_timeout;

    logic [REG_NUM-1:0] w_pend_nxt;
    logic               w_rs_ld, w_rt_ld, w_rs_br, w_rt_br;
    logic               w_ldbr, w_mdu_hz, w_dstall, w_fire, w_set;
    logic               w_unused;

    // ll_m is covered by the scoreboard once the producer leaves E
    assign w_unused = bus.ll_m;

    // Four bypass selects: D operands (branch compare) and E operands (ALU)
    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_ad (.i_src(bus.rs_d), .i_wreg_m(bus.wreg_m), .i_wreg_w(bus.wreg_w),
                                            .i_we_m(bus.we_m), .i_we_w(bus.we_w), .o_sel(bus.fwd_ad));
    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_bd (.i_src(bus.rt_d), .i_wreg_m(bus.wreg_m), .i_wreg_w(bus.wreg_w),
                                            .i_we_m(bus.we_m), .i_we_w(bus.we_w), .o_sel(bus.fwd_bd));
    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_ae (.i_src(bus.rs_e), .i_wreg_m(bus.wreg_m), .i_wreg_w(bus.wreg_w),
                                            .i_we_m(bus.we_m), .i_we_w(bus.we_w), .o_sel(bus.fwd_ae));
    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_be (.i_src(bus.rt_e), .i_wreg_m(bus.wreg_m), .i_wreg_w(bus.wreg_w),
                                            .i_we_m(bus.we_m), .i_we_w(bus.we_w), .o_sel(bus.fwd_be));

    // Hazard detection. A load still in E is caught directly; once it has
    // moved on, the scoreboard holds it until W writes back. The W write in
    // the same cycle releases the stall (regfile/W bypass supplies the value).
    always_comb begin
        w_rs_ld = bus.use_rs_d && (bus.rs_d != '0) &&
                  ((r_pend[bus.rs_d] && !(bus.we_w && (bus.wreg_w == bus.rs_d))) ||
                   (bus.we_e && bus.ll_e && (bus.wreg_e == bus.rs_d)));
        w_rt_ld = bus.use_rt_d && (bus.rt_d != '0) &&
                  ((r_pend[bus.rt_d] && !(bus.we_w && (bus.wreg_w == bus.rt_d))) ||
                   (bus.we_e && bus.ll_e && (bus.wreg_e == bus.rt_d)));
        w_rs_br = bus.cmp_d && bus.use_rs_d && (bus.rs_d != '0) &&
                  bus.we_e && (bus.wreg_e == bus.rs_d);
        w_rt_br = bus.cmp_d && bus.use_rt_d && (bus.rt_d != '0) &&
                  bus.we_e && (bus.wreg_e == bus.rt_d);
        w_ldbr   = w_rs_ld || w_rt_ld || w_rs_br || w_rt_br;
        w_mdu_hz = bus.mdu_busy_e;
        w_dstall = w_ldbr || w_mdu_hz;
        // Flush fires when unfrozen: fresh exception in IDLE, or the release
        // cycle of a latched one, so redirect never lags by a cycle
        w_fire   = !bus.mem_stall &&
                   (((r_state == ST_IDLE) && bus.except_m) ||
                    (r_state == ST_PEND) || (r_state == ST_FLUSH));
    end

    // Stall/flush output priority: freeze > exception flush > normal interlock
    always_comb begin
        bus.stall_f      = 1'b0;
        bus.stall_d      = 1'b0;
        bus.stall_e      = 1'b0;
        bus.stall_m      = 1'b0;
        bus.stall_w      = 1'b0;
        bus.flush_d      = 1'b0;
        bus.flush_e      = 1'b0;
        bus.flush_m      = 1'b0;
        bus.flush_w      = 1'b0;
        bus.exc_redirect = 1'b0;
        if (bus.mem_stall) begin
            bus.stall_f = 1'b1;
            bus.stall_d = 1'b1;
            bus.stall_e = 1'b1;
            bus.stall_m = 1'b1;
            bus.stall_w = 1'b1;
        end else if (w_fire) begin
            bus.flush_d      = 1'b1;
            bus.flush_e      = 1'b1;
            bus.flush_m      = 1'b1;
            bus.flush_w      = 1'b1;
            bus.exc_redirect = 1'b1;
        end else begin
            bus.stall_f = w_dstall;
            bus.stall_d = w_dstall;
            bus.stall_e = w_mdu_hz;
            bus.flush_e = w_ldbr && !w_mdu_hz;
            bus.flush_m = w_mdu_hz;
        end
    end

    assign bus.stall_timeout = r_timeout;

    // Next scoreboard value: retire W write, then a new producer (set wins)
    always_comb begin
        w_set = bus.we_e && bus.ll_e && (bus.wreg_e != '0) && !bus.stall_e && !bus.flush_m;
        w_pend_nxt = r_pend;
        if (bus.we_w) w_pend_nxt[bus.wreg_w] = 1'b0;
        if (w_set)    w_pend_nxt[bus.wreg_e] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    // Scoreboard register: frozen under mem_stall, wiped by exception flush
    always_ff @(posedge clk) begin
        if (!resetn)             r_pend <= '0;
        else if (bus.mem_stall)  r_pend <= r_pend;
        else if (w_fire)         r_pend <= '0;
        else                     r_pend <= w_pend_nxt;
    end

    // Exception FSM: latch an exception that arrives during a freeze;
    // FLUSH is only a safe fallback and returns to IDLE like PEND does
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.except_m && bus.mem_stall) r_state <= ST_PEND;
                ST_PEND:  if (!bus.mem_stall)                r_state <= ST_IDLE;
                ST_FLUSH: if (!bus.mem_stall)                r_state <= ST_IDLE;
                default:                                     r_state <= ST_IDLE;
            endcase
        end
    end

    // Watchdog: count consecutive D stalls, flag sticks once the limit is hit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (bus.stall_d) begin
            if (r_wdog != c_wdog_max) r_wdog <= r_wdog + 1'b1;
            if (r_wdog >= c_wdog_pre) r_timeout <= 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_sb
//  Description : Self-checking bench for hazard_ctrl_sb (WDOG_MAX = 8).
//                Observed vector: {stall_f,d,e,m,w, flush_d,e,m,w,
//                fwd_ad,bd,ae,be, exc_redirect, stall_timeout}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_sb;

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    logic clk;
    logic resetn;
    exp_t q[$];
    int   n_chk;
    int   n_pass;

    hazard_ctrl_sb_if #(.REG_AW(5)) hif ();

    hazard_ctrl_sb #(.REG_NUM(32), .REG_AW(5), .WDOG_MAX(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] ev(logic [4:0] s, logic [3:0] f, logic [7:0] w, logic r, logic t);
        return {s, f, w, r, t};
    endfunction

    function automatic logic [18:0] observe();
        return {hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m, hif.stall_w,
                hif.flush_d, hif.flush_e, hif.flush_m, hif.flush_w,
                hif.fwd_ad, hif.fwd_bd, hif.fwd_ae, hif.fwd_be,
                hif.exc_redirect, hif.stall_timeout};
    endfunction

    task automatic clr_in();
        hif.rs_d = '0; hif.rt_d = '0; hif.rs_e = '0; hif.rt_e = '0;
        hif.wreg_e = '0; hif.wreg_m = '0; hif.wreg_w = '0;
        hif.use_rs_d = 0; hif.use_rt_d = 0; hif.cmp_d = 0;
        hif.we_e = 0; hif.we_m = 0; hif.we_w = 0;
        hif.ll_e = 0; hif.ll_m = 0; hif.mdu_busy_e = 0;
        hif.except_m = 0; hif.mem_stall = 0;
    endtask

    task automatic test_reset();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 3; c++) begin
            clr_in();
            resetn = (c == 2);
            q.push_back('{$sformatf("reset_c%0d", c), ev(5'b0, 4'b0, 8'b0, 0, 0)});
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 6; c++) begin
            clr_in();
            case (c)
                0: begin hif.we_e = 1; hif.ll_e = 1; hif.wreg_e = 5; hif.use_rs_d = 1; hif.rs_d = 5;
                         q.push_back('{"ld_e_stall", ev(5'b11000, 4'b0100, 8'b0, 0, 0)}); end
                1: begin hif.we_m = 1; hif.ll_m = 1; hif.wreg_m = 5; hif.use_rs_d = 1; hif.rs_d = 5;
                         q.push_back('{"ld_m_pend", ev(5'b11000, 4'b0100, 8'b10_00_00_00, 0, 0)}); end
                2: begin hif.we_w = 1; hif.wreg_w = 5; hif.use_rs_d = 1; hif.rs_d = 5; hif.rs_e = 5;
                         q.push_back('{"ld_w_release", ev(5'b0, 4'b0, 8'b01_00_01_00, 0, 0)}); end
                3: begin hif.use_rs_d = 1; hif.rs_d = 5;
                         q.push_back('{"ld_pend_clr", ev(5'b0, 4'b0, 8'b0, 0, 0)}); end
                4: begin hif.we_e = 1; hif.ll_e = 1; hif.wreg_e = 6; hif.use_rt_d = 1; hif.rt_d = 6;
                         q.push_back('{"ld_rt_stall", ev(5'b11000, 4'b0100, 8'b0, 0, 0)}); end
                default: begin hif.we_w = 1; hif.wreg_w = 6; hif.use_rt_d = 1; hif.rt_d = 6;
                         q.push_back('{"ld_rt_wfwd", ev(5'b0, 4'b0, 8'b00_01_00_00, 0, 0)}); end
            endcase
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 5; c++) begin
            clr_in();
            case (c)
                0: begin hif.cmp_d = 1; hif.use_rs_d = 1; hif.rs_d = 3; hif.we_e = 1; hif.wreg_e = 3;
                         q.push_back('{"br_e_stall", ev(5'b11000, 4'b0100, 8'b0, 0, 0)}); end
                1: begin hif.cmp_d = 1; hif.use_rs_d = 1; hif.rs_d = 3; hif.we_m = 1; hif.wreg_m = 3;
                         q.push_back('{"br_m_fwd", ev(5'b0, 4'b0, 8'b10_00_00_00, 0, 0)}); end
                2: begin hif.cmp_d = 1; hif.use_rt_d = 1; hif.rt_d = 7; hif.we_e = 1; hif.wreg_e = 7;
                         q.push_back('{"br_rt_stall", ev(5'b11000, 4'b0100, 8'b0, 0, 0)}); end
                3: begin hif.use_rs_d = 1; hif.rs_d = 3; hif.we_e = 1; hif.wreg_e = 3;
                         q.push_back('{"nobr_nostall", ev(5'b0, 4'b0, 8'b0, 0, 0)}); end
                default: begin hif.cmp_d = 1; hif.rs_d = 3; hif.we_e = 1; hif.wreg_e = 3;
                         q.push_back('{"br_unused_src", ev(5'b0, 4'b0, 8'b0, 0, 0)}); end
            endcase
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fwd();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 4; c++) begin
            clr_in();
            case (c)
                0: begin hif.rs_e = 3; hif.rt_e = 4; hif.we_m = 1; hif.wreg_m = 3; hif.we_w = 1; hif.wreg_w = 4;
                         q.push_back('{"fwd_m_and_w", ev(5'b0, 4'b0, 8'b00_00_10_01, 0, 0)}); end
                1: begin hif.rs_e = 3; hif.rt_e = 3; hif.rs_d = 3; hif.we_m = 1; hif.wreg_m = 3;
                         hif.we_w = 1; hif.wreg_w = 3;
                         q.push_back('{"fwd_m_beats_w", ev(5'b0, 4'b0, 8'b10_00_10_10, 0, 0)}); end
                2: begin hif.rs_e = 3; hif.wreg_m = 3; hif.we_w = 1; hif.wreg_w = 3;
                         q.push_back('{"fwd_m_no_we", ev(5'b0, 4'b0, 8'b00_00_01_00, 0, 0)}); end
                default: begin hif.we_m = 1; hif.we_w = 1;
                         q.push_back('{"fwd_r0_never", ev(5'b0, 4'b0, 8'b0, 0, 0)}); end
            endcase
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 2; c++) begin
            clr_in();
            hif.use_rs_d = 1; hif.use_rt_d = 1; hif.cmp_d = 1;
            if (c == 0) begin hif.we_e = 1; hif.ll_e = 1; end
            q.push_back('{$sformatf("zero_reg_c%0d", c), ev(5'b0, 4'b0, 8'b0, 0, 0)});
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mdu();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 5; c++) begin
            clr_in();
            if (c < 4) begin
                hif.mdu_busy_e = 1; hif.we_e = 1; hif.ll_e = 1; hif.wreg_e = 8;
                q.push_back('{$sformatf("mdu_c%0d", c), ev(5'b11100, 4'b0010, 8'b0, 0, 0)});
            end else begin
                hif.use_rs_d = 1; hif.rs_d = 8;
                q.push_back('{"mdu_release", ev(5'b0, 4'b0, 8'b0, 0, 0)});
            end
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exception();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 8; c++) begin
            clr_in();
            case (c)
                0: begin hif.we_e = 1; hif.ll_e = 1; hif.wreg_e = 9;
                         q.push_back('{"exc_pre_load", ev(5'b0, 4'b0, 8'b0, 0, 0)}); end
                1: begin hif.except_m = 1; hif.mem_stall = 1;
                         q.push_back('{"exc_latched", ev(5'b11111, 4'b0, 8'b0, 0, 0)}); end
                2, 3: begin hif.mem_stall = 1;
                         q.push_back('{$sformatf("exc_frozen_c%0d", c), ev(5'b11111, 4'b0, 8'b0, 0, 0)}); end
                4: q.push_back('{"exc_release", ev(5'b0, 4'b1111, 8'b0, 1, 0)});
                5: begin hif.use_rs_d = 1; hif.rs_d = 9;
                         q.push_back('{"exc_once_pendclr", ev(5'b0, 4'b0, 8'b0, 0, 0)}); end
                6: begin hif.except_m = 1; hif.mdu_busy_e = 1;
                         q.push_back('{"exc_fast_path", ev(5'b0, 4'b1111, 8'b0, 1, 0)}); end
                default: q.push_back('{"exc_fast_done", ev(5'b0, 4'b0, 8'b0, 0, 0)});
            endcase
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_watchdog();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 12; c++) begin
            clr_in();
            if (c < 10) begin
                hif.mdu_busy_e = 1;
                q.push_back('{$sformatf("wdog_stall_c%0d", c), ev(5'b11100, 4'b0010, 8'b0, 0, (c >= 8))});
            end else begin
                q.push_back('{$sformatf("wdog_sticky_c%0d", c), ev(5'b0, 4'b0, 8'b0, 0, 1)});
            end
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [18:0] obs;
        for (int c = 0; c < 5; c++) begin
            clr_in();
            resetn = 1'b1;
            case (c)
                0: begin resetn = 0;
                         q.push_back('{"rst_before_edge", ev(5'b0, 4'b0, 8'b0, 0, 1)}); end
                1: q.push_back('{"rst_timeout_clr", ev(5'b0, 4'b0, 8'b0, 0, 0)});
                2: begin hif.except_m = 1; hif.mem_stall = 1;
                         q.push_back('{"rst_enter_pend", ev(5'b11111, 4'b0, 8'b0, 0, 0)}); end
                3: begin resetn = 0; hif.mem_stall = 1;
                         q.push_back('{"rst_in_pend", ev(5'b11111, 4'b0, 8'b0, 0, 0)}); end
                default: q.push_back('{"rst_pend_dropped", ev(5'b0, 4'b0, 8'b0, 0, 0)});
            endcase
            @(negedge clk);
            e = q.pop_front(); obs = observe(); n_chk++;
            if (obs !== e.v) $display("FAIL %s: got %b want %b", e.tag, obs, e.v); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        resetn = 1'b0;
        clr_in();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_fwd();
        test_zero_reg();
        test_mdu();
        test_exception();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
